// File: rtl/dma_desc_sched_pkg.sv
// Shared types and sizing for the DMA descriptor scheduler.
package dma_desc_sched_pkg;

  localparam int DMA_NUM_DESC   = 4;
  localparam int DMA_ADDR_WIDTH = 16;
  localparam int DMA_IDX_W      = (DMA_NUM_DESC > 1) ? $clog2(DMA_NUM_DESC) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} dma_sched_st_t;

endpackage

// File: rtl/dma_desc_sched_if.sv
// CSR-side and engine-side signals of the descriptor scheduler.
interface dma_desc_sched_if #(
  parameter int NUM_DESC = dma_desc_sched_pkg::DMA_NUM_DESC,
  parameter int BYTES_W  = dma_desc_sched_pkg::DMA_ADDR_WIDTH,
  parameter int IDX_W    = (NUM_DESC > 1) ? $clog2(NUM_DESC) : 1
);
  logic                        go;
  logic                        abort;
  logic [NUM_DESC-1:0]         desc_en;
  logic [NUM_DESC*BYTES_W-1:0] desc_bytes;
  logic                        xfer_req;
  logic [IDX_W-1:0]            xfer_idx;
  logic                        xfer_ack;
  logic                        xfer_done;
  logic                        xfer_err;
  logic                        busy;
  logic                        dma_done;
  logic                        dma_error;

  modport master (
    input  go, abort, desc_en, desc_bytes, xfer_ack, xfer_done, xfer_err,
    output xfer_req, xfer_idx, busy, dma_done, dma_error
  );

  modport slave (
    output go, abort, desc_en, desc_bytes, xfer_ack, xfer_done, xfer_err,
    input  xfer_req, xfer_idx, busy, dma_done, dma_error
  );
endinterface

// File: rtl/dma_desc_sched_prio_enc.sv
// Lowest-set-bit encoder; valid is low when the vector is empty.
module dma_prio_enc #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         valid
);
  // Scan downward so the lowest set bit is written last and wins.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = W'(i);
    end
  end

  assign valid = |vec;
endmodule

// File: rtl/dma_desc_sched.sv
// Snapshots enabled non-empty descriptors on a go edge and issues them in
// ascending order to the transfer engine, reporting sticky done/error.
module dma_desc_sched
  import dma_desc_sched_pkg::*;
#(
  parameter int NUM_DESC = DMA_NUM_DESC,
  parameter int BYTES_W  = DMA_ADDR_WIDTH,
  parameter int IDX_W    = (NUM_DESC > 1) ? $clog2(NUM_DESC) : 1
) (
  input logic clk,
  input logic rst,
  dma_desc_sched_if.master bus
);
  dma_sched_st_t       st, st_nxt;
  logic [NUM_DESC-1:0] snap, pending;
  logic [IDX_W-1:0]    snap_idx, pend_idx, idx;
  logic                snap_vld, pend_vld;
  logic                go_q, abort_q, req, busy, done, error;
  logic                go_edge, abort_any;

  always_comb begin
    snap = '0;
    for (int i = 0; i < NUM_DESC; i++)
      snap[i] = bus.desc_en[i] & (|bus.desc_bytes[i*BYTES_W +: BYTES_W]);
  end

  dma_prio_enc #(.N(NUM_DESC), .W(IDX_W)) u_snap_enc (
    .vec(snap), .idx(snap_idx), .valid(snap_vld)
  );

  dma_prio_enc #(.N(NUM_DESC), .W(IDX_W)) u_pend_enc (
    .vec(pending), .idx(pend_idx), .valid(pend_vld)
  );

  assign go_edge   = bus.go & ~go_q;
  assign abort_any = abort_q | bus.abort;

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (go_edge) st_nxt = snap_vld ? ISSUE : FIN;
      ISSUE:   if (bus.xfer_ack) st_nxt = WAIT;
               else if (abort_any) st_nxt = FIN;
      // An engine error ends the run even when an abort is also pending.
      WAIT:    if (bus.xfer_done)
                 st_nxt = (bus.xfer_err || abort_any || !pend_vld) ? FIN : ISSUE;
      FIN:     st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= IDLE;
      pending <= '0;
      go_q    <= 1'b0;
      abort_q <= 1'b0;
      req     <= 1'b0;
      idx     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      go_q <= bus.go;
      st   <= st_nxt;
      if (st != IDLE) abort_q <= abort_any;
      case (st)
        IDLE: if (go_edge) begin
          pending <= snap;
          done    <= 1'b0;
          error   <= 1'b0;
          abort_q <= 1'b0;
          busy    <= 1'b1;
          if (snap_vld) begin
            req <= 1'b1;
            idx <= snap_idx;
          end
        end
        ISSUE: begin
          if (bus.xfer_ack) begin
            pending[idx] <= 1'b0;
            req          <= 1'b0;
          end else if (abort_any) begin
            req <= 1'b0;
          end
        end
        WAIT: if (bus.xfer_done) begin
          if (bus.xfer_err) error <= 1'b1;
          else if (st_nxt == ISSUE) begin
            req <= 1'b1;
            idx <= pend_idx;
          end
        end
        FIN: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.xfer_req  = req;
  assign bus.xfer_idx  = idx;
  assign bus.busy      = busy;
  assign bus.dma_done  = done;
  assign bus.dma_error = error;
endmodule
